// File: rtl/enigma_pkg.sv
// Shared types for the Enigma message arbiter: symbol type, FSM states and the
// letter classifier used to decide whether a symbol goes through the core.
// No ports; imported by enigma_rr_grant and enigma_msg_arbiter.
package enigma_pkg;

  typedef logic [6:0] symb_t;

  localparam int    LETTERS   = 26;
  localparam symb_t SYMB_IDLE = '0;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    ACCEPT,
    WAIT,
    OUT
  } arb_state_e;

  // Letters are 1..max_letter; 0 and anything above are passed through untouched.
  function automatic logic is_letter(input logic [31:0] symb, input logic [31:0] max_letter);
    return (symb != 32'd0) && (symb <= max_letter);
  endfunction

endpackage

// File: rtl/enigma_rr_grant.sv
// Two-way round-robin grant; pointer moves off the channel that just finished a message.
// Latency: grant is combinational from req_i; pointer updates one cycle after upd_i.
// Backpressure: none; the caller decides when a grant is taken and when a message ends.
// Ports: clk_i/rst_i (async active-low), req_i per-channel request, upd_i message done,
//        served_i channel that finished, gnt_vld_o any request, gnt_idx_o chosen channel.
module enigma_rr_grant (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       served_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);
  import enigma_pkg::*;

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    // After a message the other channel gets priority for the next contention.
    if (upd_i) begin
      ptr_d = ~served_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
  end

endmodule

// File: rtl/enigma_msg_arbiter.sv
// Shares one Enigma core between two requesters, a whole message at a time, with a
// core rotor reset before each message; non-letters bypass the core.
// Latency: letter accept->out_valid 2 cycles, bypass 1 cycle; one symbol in flight.
// Backpressure: req_ready_o low outside ACCEPT; output held stable until out_ready_i.
// Ports: req_* per-channel symbol stream, out_* result stream tagged with out_src_o,
//        core_* to/from the cipher core (core result valid in the cycle it is fed),
//        msg_cnt_o letters enciphered in the current or last message (saturating).
module enigma_msg_arbiter #(
  parameter int SYMB_W  = 7,
  parameter int LETTERS = 26,
  parameter int CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0][SYMB_W-1:0] req_symb_i,
  input  logic [1:0]             req_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [SYMB_W-1:0]      out_symb_o,
  output logic                   out_last_o,
  output logic                   out_src_o,
  output logic                   core_rst_n_o,
  output logic [SYMB_W-1:0]      core_symb_o,
  input  logic [SYMB_W-1:0]      core_symb_i,
  output logic [CNT_W-1:0]       msg_cnt_o
);
  import enigma_pkg::*;

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [SYMB_W-1:0] out_symb_q, out_symb_d;
  logic              out_last_q, out_last_d;
  logic              out_src_q, out_src_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic [SYMB_W-1:0] core_symb_q, core_symb_d;
  logic [CNT_W-1:0]  msg_cnt_q, msg_cnt_d;

  logic              rr_vld;
  logic              rr_idx;
  logic              rr_upd;
  logic              in_hs;
  logic              out_hs;
  logic [SYMB_W-1:0] sel_symb;

  enigma_rr_grant u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .upd_i     (rr_upd),
    .served_i  (gnt_q),
    .gnt_vld_o (rr_vld),
    .gnt_idx_o (rr_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    out_symb_d  = out_symb_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    msg_cnt_d   = msg_cnt_q;
    core_symb_d = SYMB_W'(SYMB_IDLE);
    rr_upd      = 1'b0;
    in_hs       = req_valid_i[gnt_q] & req_ready_q[gnt_q];
    out_hs      = out_valid_q & out_ready_i;
    sel_symb    = req_symb_i[gnt_q];

    unique case (state_q)
      IDLE: begin
        if (rr_vld) begin
          gnt_d     = rr_idx;
          msg_cnt_d = '0;
          state_d   = CRST;
        end
      end
      CRST: begin
        state_d = ACCEPT;
      end
      ACCEPT: begin
        if (in_hs) begin
          out_last_d = req_last_i[gnt_q];
          out_src_d  = gnt_q;
          if (is_letter(32'(sel_symb), 32'(LETTERS))) begin
            // Core bus carries the letter for exactly the WAIT cycle.
            core_symb_d = sel_symb;
            msg_cnt_d   = (&msg_cnt_q) ? msg_cnt_q : msg_cnt_q + CNT_W'(1);
            state_d     = WAIT;
          end else begin
            out_symb_d = sel_symb;
            state_d    = OUT;
          end
        end
      end
      WAIT: begin
        out_symb_d = core_symb_i;
        state_d    = OUT;
      end
      OUT: begin
        if (out_hs) begin
          if (out_last_q) begin
            rr_upd  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake-facing outputs are decoded from the next state so they are flops.
    req_ready_d = '0;
    if (state_d == ACCEPT) begin
      req_ready_d[gnt_d] = 1'b1;
    end
    out_valid_d  = (state_d == OUT);
    core_rst_n_d = (state_d != CRST);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      req_ready_q  <= '0;
      out_valid_q  <= 1'b0;
      out_symb_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_symb_q  <= '0;
      msg_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      req_ready_q  <= req_ready_d;
      out_valid_q  <= out_valid_d;
      out_symb_q   <= out_symb_d;
      out_last_q   <= out_last_d;
      out_src_q    <= out_src_d;
      core_rst_n_q <= core_rst_n_d;
      core_symb_q  <= core_symb_d;
      msg_cnt_q    <= msg_cnt_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_symb_o   = out_symb_q;
  assign out_last_o   = out_last_q;
  assign out_src_o    = out_src_q;
  assign core_rst_n_o = core_rst_n_q;
  assign core_symb_o  = core_symb_q;
  assign msg_cnt_o    = msg_cnt_q;

endmodule
